danger_scheduler: RTL and testbench

Sequencing controller for the three obstacle slots drawn by the danger renderer. On every game tick it moves active dangers left by the current speed, retires those that leave the screen, and spawns new ones from a pseudo-random type/gap generator into the lowest free slot. Its registered slot outputs drive the renderer's `new_danger_pos1..3`, `danger_type1..3` and `danger_en1..3` inputs directly. It also sits beside the collision/score logic that issues `start`/`stop`.

---
 rtl/danger_scheduler_if.sv | 48 ++++
 rtl/danger_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_danger_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/danger_scheduler_if.sv
// danger_scheduler_if
//   Bundles the game-control inputs and the slot outputs of the danger scheduler.
//   master : the game/collision logic side. It drives tick/start/stop/speed/bird_en
//            and observes the slots.
//   slave  : the scheduler itself.
//   Signals:
//     tick, start, stop      one-cycle control pulses
//     speed[3:0]             pixels moved per tick
//     bird_en                0 replaces bird types with SMALL_CACTUS
//     danger_posN[9:0]       right-edge x of slot N
//     danger_typeN[2:0]      obstacle type of slot N
//     danger_enN             slot N active
//     spawn                  one-cycle pulse when a slot is loaded
//     running                high while a run is in progress
interface danger_scheduler_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic [3:0] speed;
  logic       bird_en;
  logic [9:0] danger_pos1;
  logic [9:0] danger_pos2;
  logic [9:0] danger_pos3;
  logic [2:0] danger_type1;
  logic [2:0] danger_type2;
  logic [2:0] danger_type3;
  logic       danger_en1;
  logic       danger_en2;
  logic       danger_en3;
  logic       spawn;
  logic       running;

  modport master (
    output tick, start, stop, speed, bird_en,
    input  danger_pos1, danger_pos2, danger_pos3,
    input  danger_type1, danger_type2, danger_type3,
    input  danger_en1, danger_en2, danger_en3,
    input  spawn, running
  );

  modport slave (
    input  tick, start, stop, speed, bird_en,
    output danger_pos1, danger_pos2, danger_pos3,
    output danger_type1, danger_type2, danger_type3,
    output danger_en1, danger_en2, danger_en3,
    output spawn, running
  );
endinterface

// File: rtl/danger_scheduler.sv
// danger_scheduler
//   Sequences the three obstacle slots of the danger renderer. Each processed tick
//   moves active slots left by speed, retires slots that reach the left edge and
//   spawns a new obstacle into the lowest free slot when the spawn gap expires.
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-low reset
//     bus   danger_scheduler_if.slave (controls in, registered slot outputs out)
//   Parameters:
//     SPAWN_X    x coordinate of a freshly spawned obstacle
//     MIN_GAP    minimum ticks between spawns
//     FIRST_GAP  gap loaded when a run starts
//     SEED       LFSR reset/restart value
module danger_scheduler #(
  parameter logic [9:0]  SPAWN_X   = 10'd720,
  parameter int unsigned MIN_GAP   = 40,
  parameter int unsigned FIRST_GAP = 60,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  danger_scheduler_if.slave bus
);

  // Gap register holds up to MIN_GAP + 31.
  localparam int GAP_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       pos_q  [3];
  logic [9:0]       pos_d  [3];
  logic [2:0]       type_q [3];
  logic [2:0]       type_d [3];
  logic [2:0]       en_q, en_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             spawn_q, spawn_d;
  logic             running_q, running_d;

  logic [9:0]       speed_s;
  logic [2:0]       new_type_s;
  logic             placed_s;

  // Fibonacci LFSR, taps 16,14,13,11; feedback enters bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Random code to obstacle type; birds (0,1) fall back to SMALL_CACTUS when disabled.
  function automatic logic [2:0] map_type(input logic [2:0] r, input logic bird_ok);
    logic [2:0] t;
    case (r)
      3'd5:    t = 3'd2;
      3'd6:    t = 3'd3;
      3'd7:    t = 3'd4;
      default: t = r;
    endcase
    if (!bird_ok && (t < 3'd2)) begin
      t = 3'd2;
    end else begin
      t = t;
    end
    return t;
  endfunction

  // Next-state logic: start/stop handling, per-tick move, gap countdown and spawn.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    type_d     = type_q;
    en_d       = en_q;
    gap_d      = gap_q;
    lfsr_d     = lfsr_q;
    spawn_d    = 1'b0;
    placed_s   = 1'b0;
    speed_s    = {6'd0, bus.speed};
    new_type_s = map_type(lfsr_q[2:0], bus.bird_en);

    case (state_q)
      S_IDLE, S_FROZEN: begin
        if (bus.start) begin
          for (int i = 0; i < 3; i++) begin
            pos_d[i]  = 10'd0;
            type_d[i] = 3'd0;
          end
          en_d    = 3'b000;
          gap_d   = GAP_W'(FIRST_GAP);
          lfsr_d  = SEED;
          state_d = S_RUN;
        end else begin
          state_d = state_q;
        end
      end

      S_RUN: begin
        if (bus.stop) begin
          // stop outranks start and tick in the same cycle
          state_d = S_FROZEN;
        end else if (bus.tick) begin
          for (int i = 0; i < 3; i++) begin
            if (en_q[i]) begin
              if (pos_q[i] <= speed_s) begin
                en_d[i]  = 1'b0;
                pos_d[i] = 10'd0;
              end else begin
                pos_d[i] = pos_q[i] - speed_s;
              end
            end else begin
              en_d[i] = en_q[i];
            end
          end

          if (gap_q != '0) begin
            gap_d = gap_q - 8'd1;
          end else if (en_q != 3'b111) begin
            // Free slots are judged on en_q, so a slot retired by this tick's
            // move only becomes usable on the next tick.
            for (int i = 0; i < 3; i++) begin
              if (!en_q[i] && !placed_s) begin
                placed_s  = 1'b1;
                en_d[i]   = 1'b1;
                pos_d[i]  = SPAWN_X;
                type_d[i] = new_type_s;
              end else begin
                placed_s = placed_s;
              end
            end
            gap_d   = GAP_W'(MIN_GAP) + GAP_W'(lfsr_q[7:3]);
            spawn_d = 1'b1;
          end else begin
            // every slot busy: keep the gap at zero and retry next tick
            gap_d = gap_q;
          end

          lfsr_d = lfsr_step(lfsr_q);
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    running_d = (state_d == S_RUN);
  end

  // State and slot registers; every output comes straight from these flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < 3; i++) begin
        pos_q[i]  <= 10'd0;
        type_q[i] <= 3'd0;
      end
      en_q      <= 3'b000;
      gap_q     <= GAP_W'(FIRST_GAP);
      lfsr_q    <= SEED;
      spawn_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      type_q    <= type_d;
      en_q      <= en_d;
      gap_q     <= gap_d;
      lfsr_q    <= lfsr_d;
      spawn_q   <= spawn_d;
      running_q <= running_d;
    end
  end

  assign bus.danger_pos1  = pos_q[0];
  assign bus.danger_pos2  = pos_q[1];
  assign bus.danger_pos3  = pos_q[2];
  assign bus.danger_type1 = type_q[0];
  assign bus.danger_type2 = type_q[1];
  assign bus.danger_type3 = type_q[2];
  assign bus.danger_en1   = en_q[0];
  assign bus.danger_en2   = en_q[1];
  assign bus.danger_en3   = en_q[2];
  assign bus.spawn        = spawn_q;
  assign bus.running      = running_q;

endmodule

// File: tb/tb_danger_scheduler.sv
// Self-checking bench for danger_scheduler: dut_a uses default parameters,
// dut_b uses MIN_GAP=0 for slot exhaustion and type-mapping coverage.
module tb_danger_scheduler;

  typedef struct packed {
    logic       spawn;
    logic       running;
    logic [2:0] en;
    logic [9:0] p1, p2, p3;
    logic [2:0] t1, t2, t3;
  } out_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  out_t sb[$];
  logic [2:0] seed_type;

  // reference model state, index 0 = dut_a, 1 = dut_b
  int         m_state [2];   // 0 idle, 1 run, 2 frozen
  logic [9:0] m_pos   [2][3];
  logic [2:0] m_type  [2][3];
  logic [2:0] m_en    [2];
  int         m_gap   [2];
  logic [15:0] m_lfsr [2];
  logic       m_spawn [2];

  danger_scheduler_if bus_a ();
  danger_scheduler_if bus_b ();

  danger_scheduler dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  danger_scheduler #(.MIN_GAP(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [2:0] exp_map(input logic [2:0] r, input logic be);
    logic [2:0] t;
    t = (r > 3'd4) ? (r - 3'd3) : r;
    if (!be && t < 3'd2) t = 3'd2;
    return t;
  endfunction

  function automatic out_t mk_exp(input int d);
    out_t o;
    o.spawn = m_spawn[d];
    o.running = (m_state[d] == 1);
    o.en = m_en[d];
    o.p1 = m_pos[d][0]; o.p2 = m_pos[d][1]; o.p3 = m_pos[d][2];
    o.t1 = m_type[d][0]; o.t2 = m_type[d][1]; o.t3 = m_type[d][2];
    return o;
  endfunction

  function automatic out_t snap(input int d);
    out_t o;
    if (d == 0)
      o = {bus_a.spawn, bus_a.running, bus_a.danger_en3, bus_a.danger_en2, bus_a.danger_en1,
           bus_a.danger_pos1, bus_a.danger_pos2, bus_a.danger_pos3,
           bus_a.danger_type1, bus_a.danger_type2, bus_a.danger_type3};
    else
      o = {bus_b.spawn, bus_b.running, bus_b.danger_en3, bus_b.danger_en2, bus_b.danger_en1,
           bus_b.danger_pos1, bus_b.danger_pos2, bus_b.danger_pos3,
           bus_b.danger_type1, bus_b.danger_type2, bus_b.danger_type3};
    return o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0; m_en[d] = 3'b000; m_gap[d] = 60;
      m_lfsr[d] = 16'hACE1; m_spawn[d] = 1'b0;
      for (int i = 0; i < 3; i++) begin m_pos[d][i] = 10'd0; m_type[d][i] = 3'd0; end
    end
  endtask

  task automatic model_step(input int d, input logic tk, input logic st, input logic sp,
                            input logic [3:0] spd, input logic be);
    logic [2:0] fr;
    int slot;
    m_spawn[d] = 1'b0;
    if (m_state[d] != 1) begin
      if (st) begin
        for (int i = 0; i < 3; i++) begin m_pos[d][i] = 10'd0; m_type[d][i] = 3'd0; end
        m_en[d] = 3'b000; m_gap[d] = 60; m_lfsr[d] = 16'hACE1; m_state[d] = 1;
      end
    end else if (sp) begin
      m_state[d] = 2;
    end else if (tk) begin
      fr = ~m_en[d];
      for (int i = 0; i < 3; i++)
        if (m_en[d][i]) begin
          if (m_pos[d][i] <= {6'd0, spd}) begin m_en[d][i] = 1'b0; m_pos[d][i] = 10'd0; end
          else m_pos[d][i] = m_pos[d][i] - {6'd0, spd};
        end
      if (m_gap[d] > 0) m_gap[d] = m_gap[d] - 1;
      else begin
        slot = -1;
        for (int i = 2; i >= 0; i--) if (fr[i]) slot = i;
        if (slot >= 0) begin
          m_en[d][slot] = 1'b1; m_pos[d][slot] = 10'd720;
          m_type[d][slot] = exp_map(m_lfsr[d][2:0], be);
          m_gap[d] = ((d == 0) ? 40 : 0) + int'(m_lfsr[d][7:3]);
          m_spawn[d] = 1'b1;
        end
      end
      m_lfsr[d] = lfsr_nx(m_lfsr[d]);
    end
  endtask

  // drive one cycle on DUT d (the other DUT idles), push the model's expectation
  task automatic step(input int d, input logic tk, input logic st, input logic sp,
                      input logic [3:0] spd, input logic be);
    if (d == 0) begin
      bus_a.tick = tk; bus_a.start = st; bus_a.stop = sp; bus_a.speed = spd; bus_a.bird_en = be;
      model_step(0, tk, st, sp, spd, be); model_step(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    end else begin
      bus_b.tick = tk; bus_b.start = st; bus_b.stop = sp; bus_b.speed = spd; bus_b.bird_en = be;
      model_step(1, tk, st, sp, spd, be); model_step(0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    end
    sb.push_back(mk_exp(d));
    @(posedge clk); #1;
    bus_a.tick = 1'b0; bus_a.start = 1'b0; bus_a.stop = 1'b0;
    bus_b.tick = 1'b0; bus_b.start = 1'b0; bus_b.stop = 1'b0;
  endtask

  task automatic test_reset();
    out_t got, want;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      got = snap(d);
      total++;
      if (got !== '0) begin bad++; $display("FAIL reset_outputs dut%0d: got %h want 0", d, got); end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 5; i++) begin
        step(d, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1);
        want = sb.pop_front(); got = snap(d);
        total++;
        if (got !== want || got !== '0) begin
          bad++; $display("FAIL idle_tick dut%0d #%0d: got %h want %h", d, i, got, want);
        end
      end
  endtask

  task automatic test_first_spawn();
    out_t got, want;
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < 60; i++) l = lfsr_nx(l);
    seed_type = exp_map(l[2:0], 1'b1);
    step(0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    want = sb.pop_front(); got = snap(0);
    total++;
    if (got !== want || got.running !== 1'b1 || got.en !== 3'b000) begin
      bad++; $display("FAIL start_run: got %h want %h", got, want);
    end
    for (int i = 1; i <= 62; i++) begin
      step(0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1);
      want = sb.pop_front(); got = snap(0);
      total++;
      if (got !== want) begin bad++; $display("FAIL first_spawn tick %0d: got %h want %h", i, got, want); end
      if (i == 60) begin
        total++;
        if (got.spawn !== 1'b0 || got.en !== 3'b000) begin
          bad++; $display("FAIL tick60_no_spawn: got spawn=%b en=%b want 0 000", got.spawn, got.en);
        end
      end
      if (i == 61) begin
        total++;
        if ({got.spawn, got.en, got.p1, got.t1} !== {1'b1, 3'b001, 10'd720, seed_type}) begin
          bad++; $display("FAIL tick61_spawn: got %b %b %0d %0d want 1 001 720 %0d",
                          got.spawn, got.en, got.p1, got.t1, seed_type);
        end
      end
      if (i == 62) begin
        total++;
        if ({got.spawn, got.en[0], got.p1} !== {1'b0, 1'b1, 10'd716}) begin
          bad++; $display("FAIL tick62_move: got spawn=%b pos1=%0d want 0 716", got.spawn, got.p1);
        end
      end
    end
  endtask

  task automatic test_retire();
    out_t got, want;
    int n, nsteps;
    logic [3:0] run_spd, spd;
    for (int c = 0; c < 2; c++) begin
      run_spd = (c == 0) ? 4'd8 : 4'd9;
      n = (c == 0) ? 89 : 79;
      nsteps = 64 + n;
      for (int k = 0; k < nsteps; k++) begin
        spd = (k < 63) ? 4'd0 : ((k == nsteps - 1) ? 4'd8 : run_spd);
        step(0, k >= 2, k == 1, k == 0, spd, 1'b1);
        want = sb.pop_front(); got = snap(0);
        total++;
        if (got !== want) begin bad++; $display("FAIL retire c%0d k%0d: got %h want %h", c, k, got, want); end
        if (k == nsteps - 2) begin
          total++;
          if ({got.en[0], got.p1} !== {1'b1, 10'd8 + 10'(c)}) begin
            bad++; $display("FAIL retire_setup c%0d: got en1=%b pos1=%0d want 1 %0d", c, got.en[0], got.p1, 8 + c);
          end
        end
        if (k == nsteps - 1) begin
          total++;
          if ({got.en[0], got.p1} !== ((c == 0) ? {1'b0, 10'd0} : {1'b1, 10'd1})) begin
            bad++; $display("FAIL retire_edge c%0d: got en1=%b pos1=%0d want %0d %0d", c, got.en[0], got.p1, c, c);
          end
        end
      end
    end
  endtask

  task automatic test_exhaustion();
    out_t got, want, prev;
    logic [2:0] lo, nb;
    int n;
    bit full;
    step(1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    want = sb.pop_front(); got = snap(1);
    total++;
    if (got !== want) begin bad++; $display("FAIL exh_start: got %h want %h", got, want); end
    prev = got; full = 1'b0; n = 0;
    while (!full && n < 300) begin
      step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      want = sb.pop_front(); got = snap(1);
      total++;
      if (got !== want) begin bad++; $display("FAIL exh_fill %0d: got %h want %h", n, got, want); end
      if (got.spawn) begin
        lo = ~prev.en; lo = lo & (~lo + 3'd1); nb = got.en & ~prev.en;
        total++;
        if (nb !== lo) begin bad++; $display("FAIL exh_order: got new %b want %b", nb, lo); end
      end
      full = (got.en == 3'b111); prev = got; n++;
    end
    total++;
    if (!full) begin bad++; $display("FAIL exh_fill_timeout: got en=%b want 111", got.en); end
    for (int i = 0; i < 88; i++) begin
      step(1, 1'b1, 1'b0, 1'b0, (i < 40) ? 4'd0 : 4'd15, 1'b1);
      want = sb.pop_front(); got = snap(1);
      total++;
      if (got !== want) begin bad++; $display("FAIL exh_hold %0d: got %h want %h", i, got, want); end
      total++;
      if (got.spawn !== 1'b0 || got.en !== ((i == 87) ? 3'b000 : 3'b111)) begin
        bad++; $display("FAIL exh_full %0d: got spawn=%b en=%b", i, got.spawn, got.en);
      end
    end
    step(1, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1);
    want = sb.pop_front(); got = snap(1);
    total++;
    if (got !== want || {got.spawn, got.en} !== {1'b1, 3'b001}) begin
      bad++; $display("FAIL exh_retry: got %h want %h", got, want);
    end
    prev = got;
    for (int i = 0; i < 400; i++) begin
      step(1, 1'b1, 1'b0, 1'b0, 4'($urandom_range(15, 1)), 1'b1);
      want = sb.pop_front(); got = snap(1);
      total++;
      if (got !== want) begin bad++; $display("FAIL exh_cycle %0d: got %h want %h", i, got, want); end
      if (got.spawn) begin
        lo = ~prev.en; lo = lo & (~lo + 3'd1); nb = got.en & ~prev.en;
        total++;
        if (nb !== lo) begin bad++; $display("FAIL exh_lowest %0d: got new %b want %b", i, nb, lo); end
      end
      prev = got;
    end
  endtask

  task automatic test_stop_start();
    out_t got, want;
    logic [3:0] spd;
    logic tk, st, sp;
    // k: 0 tick, 1 stop+tick, 2 tick(frozen), 3 stop(frozen), 4 idle, 5 start,
    //    6..66 ticks (61), 67 start+stop in RUN, 68 start+stop in FROZEN
    for (int k = 0; k < 69; k++) begin
      tk = (k <= 2) || (k >= 6 && k <= 66);
      sp = (k == 1) || (k == 3) || (k >= 67);
      st = (k == 5) || (k >= 67);
      spd = (k <= 2) ? 4'd5 : 4'd2;
      step(0, tk, st, sp, spd, 1'b1);
      want = sb.pop_front(); got = snap(0);
      total++;
      if (got !== want) begin bad++; $display("FAIL stopstart k%0d: got %h want %h", k, got, want); end
      if (k == 1 || k == 67) begin
        total++;
        if (got.running !== 1'b0) begin bad++; $display("FAIL stop_wins k%0d: got running=%b want 0", k, got.running); end
      end
      if (k == 5 || k == 68) begin
        total++;
        if (got.running !== 1'b1 || (k == 5 && got.en !== 3'b000)) begin
          bad++; $display("FAIL restart k%0d: got running=%b en=%b want 1 000", k, got.running, got.en);
        end
      end
      if (k == 65 || k == 66) begin
        total++;
        if ({got.spawn, got.en} !== ((k == 66) ? {1'b1, 3'b001} : 4'b0000) || (k == 66 && got.t1 !== seed_type)) begin
          bad++; $display("FAIL restart_gap k%0d: got spawn=%b en=%b type=%0d want type %0d", k, got.spawn, got.en, got.t1, seed_type);
        end
      end
    end
  endtask

  task automatic test_bird();
    out_t got, want, prev;
    logic [2:0] r, nb, t;
    logic be;
    int cov [2][2];
    cov = '{'{0, 0}, '{0, 0}};
    prev = snap(1);
    for (int i = 0; i < 3000; i++) begin
      be = 1'($urandom_range(1, 0));
      r = m_lfsr[1][2:0];
      step(1, 1'b1, 1'b0, 1'b0, 4'($urandom_range(15, 8)), be);
      want = sb.pop_front(); got = snap(1);
      total++;
      if (got !== want) begin bad++; $display("FAIL bird %0d: got %h want %h", i, got, want); end
      nb = got.en & ~prev.en;
      if (got.spawn && r <= 3'd1) begin
        t = nb[0] ? got.t1 : (nb[1] ? got.t2 : got.t3);
        cov[be][r[0]]++;
        total++;
        if (t !== (be ? r : 3'd2)) begin
          bad++; $display("FAIL bird_type r=%0d be=%b: got %0d want %0d", r, be, t, be ? r : 3'd2);
        end
      end
      prev = got;
    end
    for (int b = 0; b < 2; b++)
      for (int j = 0; j < 2; j++) begin
        total++;
        if (cov[b][j] == 0) begin bad++; $display("FAIL bird_cover be=%0d r=%0d: got 0 hits want >0", b, j); end
      end
  endtask

  task automatic test_async_reset();
    out_t got, want;
    step(0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
    want = sb.pop_front(); got = snap(0);
    total++;
    if (got !== want) begin bad++; $display("FAIL pre_reset: got %h want %h", got, want); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      sb.push_back(mk_exp(d));
      want = sb.pop_front(); got = snap(d);
      total++;
      if (got !== want || got !== '0) begin bad++; $display("FAIL async_reset dut%0d: got %h want %h", d, got, want); end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
    want = sb.pop_front(); got = snap(0);
    total++;
    if (got !== want) begin bad++; $display("FAIL post_reset_idle: got %h want %h", got, want); end
  endtask

  initial begin
    bus_a.tick = 1'b0; bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.speed = 4'd0; bus_a.bird_en = 1'b1;
    bus_b.tick = 1'b0; bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.speed = 4'd0; bus_b.bird_en = 1'b1;
    seed_type = 3'd0;
    model_reset();
    test_reset();
    test_first_spawn();
    test_retire();
    test_exhaustion();
    test_stop_start();
    test_bird();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
